// File: rtl/grn_gen_if.sv
// Control/sample bundle between the Gaussian source and its consumer.
interface grn_gen_if;
  logic        en;
  logic        load_seed;
  logic [31:0] seed;
  logic        tst_sel;
  logic [19:0] tst_sum;
  logic [31:0] dout;
  logic        dout_valid;
  logic [31:0] nsamples;

  modport master (
    output en, load_seed, seed, tst_sel, tst_sum,
    input  dout, dout_valid, nsamples
  );

  modport slave (
    input  en, load_seed, seed, tst_sel, tst_sum,
    output dout, dout_valid, nsamples
  );
endinterface

// File: rtl/grn_gen.sv
// Central-limit Gaussian source: sum of 12 LFSR uniforms minus 6, emitted as an exact
// IEEE-754 single through a 4-stage pipeline that advances only when enabled.
module grn_gen #(
  parameter logic [31:0] SEED   = 32'hACE12461,
  parameter logic [31:0] GOLDEN = 32'h9E3779B9
) (
  input  logic       clk,
  input  logic       reset,
  grn_gen_if.slave   bus
);
  localparam logic [31:0] TAPS = 32'h80200003;

  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int idx);
    logic [31:0] s;
    s = base ^ (32'(idx) * GOLDEN);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  logic        w_adv;
  logic [31:0] r_lane [12];
  logic [15:0] w_u [12];
  logic [17:0] w_psum [4];
  logic [17:0] r_s1_psum [4];
  logic [19:0] w_tree;
  logic [19:0] w_s2_in;
  logic [20:0] w_z;
  logic [20:0] r_s2_z;
  logic [19:0] w_mag;
  logic [4:0]  w_lead;
  logic        r_s3_sign;
  logic [19:0] r_s3_mag;
  logic [4:0]  r_s3_p;
  logic        r_s3_zero;
  logic [18:0] w_frac_hi;
  logic [7:0]  w_exp;
  logic [31:0] w_fp;
  logic [31:0] r_dout;
  logic [2:0]  r_fill;
  logic [31:0] r_nsamp;

  assign w_adv = bus.en & ~bus.load_seed;

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_lane
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          r_lane[gi] <= lane_seed(SEED, gi);
        else if (bus.load_seed)
          r_lane[gi] <= lane_seed(bus.seed, gi);
        else if (w_adv)
          r_lane[gi] <= (r_lane[gi] >> 1) ^ (r_lane[gi][0] ? TAPS : 32'h0);
      end
      assign w_u[gi] = r_lane[gi][31:16];
    end

    for (gi = 0; gi < 4; gi++) begin : g_psum
      assign w_psum[gi] = 18'(w_u[3*gi]) + 18'(w_u[3*gi+1]) + 18'(w_u[3*gi+2]);
    end
  endgenerate

  assign w_tree  = 20'(r_s1_psum[0]) + 20'(r_s1_psum[1]) + 20'(r_s1_psum[2]) + 20'(r_s1_psum[3]);
  assign w_s2_in = bus.tst_sel ? bus.tst_sum : w_tree;
  assign w_z     = {1'b0, w_s2_in} - 21'h60000;

  // |z| of the most negative value (-6.0) still fits in 20 bits.
  assign w_mag = r_s2_z[20] ? 20'(-r_s2_z) : r_s2_z[19:0];

  always_comb begin
    w_lead = 5'd0;
    for (int k = 0; k < 20; k++)
      if (w_mag[k]) w_lead = 5'(k);
  end

  // Normalise so the leading one sits at bit 19 and drop it; the 19 bits below are the fraction.
  assign w_frac_hi = 19'(r_s3_mag << (5'd19 - r_s3_p));
  assign w_exp     = 8'd111 + {3'b000, r_s3_p};
  assign w_fp      = r_s3_zero ? 32'h0 : {r_s3_sign, w_exp, w_frac_hi, 4'b0000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.load_seed) begin
      for (int k = 0; k < 4; k++) r_s1_psum[k] <= '0;
      r_s2_z    <= '0;
      r_s3_sign <= 1'b0;
      r_s3_mag  <= '0;
      r_s3_p    <= '0;
      r_s3_zero <= 1'b0;
      r_dout    <= '0;
      r_fill    <= '0;
      r_nsamp   <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < 4; k++) r_s1_psum[k] <= w_psum[k];
      r_s2_z    <= w_z;
      r_s3_sign <= r_s2_z[20];
      r_s3_mag  <= w_mag;
      r_s3_p    <= w_lead;
      r_s3_zero <= (w_mag == 20'h0);
      r_dout    <= w_fp;
      if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
      if (r_fill >= 3'd3) r_nsamp <= r_nsamp + 32'd1;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = (r_fill == 3'd4);
  assign bus.nsamples   = r_nsamp;
endmodule

// File: tb/tb_grn_gen.sv
// Scoreboard bench for grn_gen: driver pushes expected samples, monitor pops on each new valid output.
module tb_grn_gen;
  localparam logic [31:0] M_SEED   = 32'hACE12461;
  localparam logic [31:0] M_GOLDEN = 32'h9E3779B9;
  localparam logic [31:0] M_TAPS   = 32'h80200003;

  logic clk = 1'b0;
  logic reset;
  grn_gen_if bus();

  grn_gen dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_lane [12];

  function automatic logic [31:0] m_seed(input logic [31:0] base, input int idx);
    logic [31:0] s;
    s = base ^ (32'(idx) * M_GOLDEN);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  // Exact float encoding via the double-precision bit pattern.
  function automatic logic [31:0] to_single(input int zq);
    real         r;
    logic [63:0] d;
    int          e;
    if (zq == 0) return 32'h0;
    r = real'(zq) / 65536.0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  task automatic model_reseed(input logic [31:0] base);
    for (int i = 0; i < 12; i++) m_lane[i] = m_seed(base, i);
  endtask

  task automatic model_push_and_step();
    int sum;
    sum = 0;
    for (int i = 0; i < 12; i++) sum += int'(m_lane[i][31:16]);
    sb_q.push_back(to_single(sum - 393216));
    for (int i = 0; i < 12; i++)
      m_lane[i] = (m_lane[i] >> 1) ^ (m_lane[i][0] ? M_TAPS : 32'h0);
  endtask

  task automatic run_lfsr(input int ncyc, input int gap_pct);
    logic e;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e = ($urandom_range(99) >= gap_pct);
      reset = 1'b0;
      bus.load_seed = 1'b0;
      bus.en = e;
      if (e) model_push_and_step();
    end
  endtask

  // Directed test-hook vectors with hand-computed encodings.
  localparam int NV = 12;
  logic [19:0] tv_sum [NV] = '{20'h50000, 20'h50000, 20'h50000, 20'h60000, 20'h80000, 20'h00000,
                               20'hBFFFF, 20'h60001, 20'h70000, 20'h68000, 20'h5C000, 20'h5FFFF};
  logic [31:0] tv_exp [NV] = '{32'hBF800000, 32'hBF800000, 32'hBF800000, 32'h00000000,
                               32'h40000000, 32'hC0C00000, 32'h40BFFFE0, 32'h37800000,
                               32'h3F800000, 32'h3F000000, 32'hBE800000, 32'hB7800000};

  initial begin
    int n;
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.load_seed = 1'b0;
    bus.seed      = 32'h0;
    bus.tst_sel   = 1'b1;
    bus.tst_sum   = 20'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Test-hook path, latency 3; outputs valid from the 4th advancing edge.
    n = 0;
    for (int j = 0; j < NV; j++) begin
      if (j % 4 == 3) begin
        @(negedge clk);
        bus.en = 1'b0;
      end
      @(negedge clk);
      bus.en = 1'b1;
      bus.tst_sum = tv_sum[j];
      n++;
      if (n >= 2) sb_q.push_back(tv_exp[j]);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      bus.en = 1'b1;
      bus.tst_sum = 20'h60000;
      sb_q.push_back(32'h0);
    end

    // LFSR path from the default seed, continuous then gapped.
    @(negedge clk);
    reset = 1'b1;
    bus.en = 1'b0;
    bus.tst_sel = 1'b0;
    model_reseed(M_SEED);
    run_lfsr(103, 0);
    run_lfsr(300, 50);

    // Reseed from 0 while enabled mid-stream.
    @(negedge clk);
    bus.load_seed = 1'b1;
    bus.en = 1'b1;
    bus.seed = 32'h0;
    model_reseed(32'h0);
    run_lfsr(300, 50);

    // Reset pulse mid-stream with en held high.
    @(negedge clk);
    reset = 1'b1;
    bus.en = 1'b1;
    model_reseed(M_SEED);
    run_lfsr(100, 0);
    run_lfsr(200, 40);

    @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: tracks expected fill/count and pops the scoreboard on each new valid sample.
  initial begin
    int          fill;
    logic [31:0] ns;
    logic [31:0] last;
    logic [31:0] exp;
    logic        r_s, l_s, e_s;
    int          popped;
    fill = 0;
    ns = 0;
    last = 0;
    popped = 0;
    forever begin
      @(posedge clk);
      r_s = reset;
      l_s = bus.load_seed;
      e_s = bus.en;
      #1;
      if (r_s || l_s) begin
        sb_q.delete();
        fill = 0;
        ns = 0;
        last = 0;
        chk("dout_after_clear", bus.dout, 32'h0);
      end else if (e_s) begin
        if (fill >= 3) ns++;
        if (fill < 4) fill++;
      end
      chk("dout_valid", {31'h0, bus.dout_valid}, {31'h0, fill == 4});
      chk("nsamples", bus.nsamples, ns);
      if (fill == 4) begin
        if (!(r_s || l_s) && e_s) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got %h expected none", bus.dout);
          end else begin
            exp = sb_q.pop_front();
            chk("dout", bus.dout, exp);
            popped++;
            $display("sample %0d dout=%h expected=%h", popped, bus.dout, exp);
            last = exp;
          end
        end else begin
          chk("dout_hold", bus.dout, last);
        end
      end
    end
  end
endmodule
